// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: round-robin arbiter feeding NCH job channels into a
// single AES core. Four-state FSM (IDLE -> LOAD -> BUSY -> RESP) with a
// one-cycle load strobe and a held result until the consumer accepts it.
// Optional BUSY watchdog is compiled in with `define AES_ARB_TIMEOUT_EN;
// without it BUSY waits for core_done indefinitely and res_err is tied 0.
module aes_job_arbiter #(
  parameter int NCH     = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     req_valid,
  output logic [NCH-1:0]     req_ready,
  input  logic [NCH*128-1:0] req_key,
  input  logic [NCH*128-1:0] req_text,
  output logic               core_ld,
  output logic [127:0]       core_key,
  output logic [127:0]       core_text_in,
  input  logic               core_done,
  input  logic [127:0]       core_text_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2:0]         res_ch,
  output logic [127:0]       res_data,
  output logic               res_err
);

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_t;

  state_t       state_reg;
  logic [2:0]   last_grant_reg;
  logic [2:0]   grant_idx_reg;
  logic         core_ld_reg;
  logic [127:0] core_key_reg;
  logic [127:0] core_text_reg;
  logic         res_valid_reg;
  logic [2:0]   res_ch_reg;
  logic [127:0] res_data_reg;

  // Channel views padded to 8 entries so a 3-bit index never leaves the array
  logic [127:0] key_arr  [8];
  logic [127:0] text_arr [8];
  logic [7:0]   valid_pad;

  logic         grant_found;
  logic [2:0]   grant_idx;

  // Reject illegal parameter values at elaboration time
  if (NCH < 1 || NCH > 8 || TIMEOUT < 2 || TIMEOUT > 1023) begin : g_bad_param
    $error("aes_job_arbiter: NCH or TIMEOUT out of range");
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_unpack
      if (gi < NCH) begin : g_live
        assign key_arr[gi]   = req_key[128*gi +: 128];
        assign text_arr[gi]  = req_text[128*gi +: 128];
        assign valid_pad[gi] = req_valid[gi];
      end else begin : g_pad
        assign key_arr[gi]   = '0;
        assign text_arr[gi]  = '0;
        assign valid_pad[gi] = 1'b0;
      end
    end
  endgenerate

  // Round-robin search starting one past the last served channel
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      int cand;
      cand = (int'(last_grant_reg) + k) % NCH;
      if (!grant_found && valid_pad[cand[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[2:0];
      end
    end
  end

  // Accept strobe is one-hot on the winner, only while IDLE
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == IDLE) && grant_found && (grant_idx == 3'(gi));
    end
  endgenerate

`ifdef AES_ARB_TIMEOUT_EN
  logic [9:0] tmo_cnt_reg;
  logic       res_err_reg;
  assign res_err = res_err_reg;
`else
  assign res_err = 1'b0;
`endif

  // Main FSM with registered core and result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 3'(NCH - 1);
      grant_idx_reg  <= '0;
      core_ld_reg    <= 1'b0;
      core_key_reg   <= '0;
      core_text_reg  <= '0;
      res_valid_reg  <= 1'b0;
      res_ch_reg     <= '0;
      res_data_reg   <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      tmo_cnt_reg    <= '0;
      res_err_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            grant_idx_reg <= grant_idx;
            core_key_reg  <= key_arr[grant_idx];
            core_text_reg <= text_arr[grant_idx];
            core_ld_reg   <= 1'b1;
            state_reg     <= LOAD;
          end
        end
        LOAD: begin
          core_ld_reg <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
          tmo_cnt_reg <= '0;
`endif
          state_reg   <= BUSY;
        end
        BUSY: begin
          if (core_done) begin
            res_data_reg  <= core_text_out;
            res_ch_reg    <= grant_idx_reg;
            res_valid_reg <= 1'b1;
`ifdef AES_ARB_TIMEOUT_EN
            res_err_reg   <= 1'b0;
`endif
            state_reg     <= RESP;
          end
`ifdef AES_ARB_TIMEOUT_EN
          // Count value n-1 in the n-th BUSY cycle; fire in BUSY cycle TIMEOUT
          else if (tmo_cnt_reg == 10'(TIMEOUT - 1)) begin
            res_data_reg  <= '0;
            res_ch_reg    <= grant_idx_reg;
            res_valid_reg <= 1'b1;
            res_err_reg   <= 1'b1;
            state_reg     <= RESP;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 10'd1;
          end
`endif
        end
        RESP: begin
          if (res_ready) begin
            res_valid_reg  <= 1'b0;
            last_grant_reg <= grant_idx_reg;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign core_ld      = core_ld_reg;
  assign core_key     = core_key_reg;
  assign core_text_in = core_text_reg;
  assign res_valid    = res_valid_reg;
  assign res_ch       = res_ch_reg;
  assign res_data     = res_data_reg;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Directed bench for aes_job_arbiter (NCH=4, TIMEOUT=16).
module tb_aes_job_arbiter;

  localparam int NCH = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NCH-1:0]     req_valid = '0;
  logic [NCH-1:0]     req_ready;
  logic [NCH*128-1:0] req_key = '0;
  logic [NCH*128-1:0] req_text = '0;
  logic               core_ld;
  logic [127:0]       core_key;
  logic [127:0]       core_text_in;
  logic               core_done = 1'b0;
  logic [127:0]       core_text_out = '0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [2:0]         res_ch;
  logic [127:0]       res_data;
  logic               res_err;

  int total = 0;
  int bad   = 0;

  logic [127:0] key_tab  [NCH];
  logic [127:0] text_tab [NCH];

  aes_job_arbiter #(.NCH(NCH), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_text(req_text),
    .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
    .core_done(core_done), .core_text_out(core_text_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_ch(res_ch), .res_data(res_data), .res_err(res_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; core_done = 1'b0; res_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic load_tables();
    for (int c = 0; c < NCH; c++) begin
      key_tab[c]  = {4{32'hA000_0000 + 32'(c)}};
      text_tab[c] = {4{32'h0000_0B00 + 32'(c)}};
      req_key[128*c +: 128]  = key_tab[c];
      req_text[128*c +: 128] = text_tab[c];
    end
  endtask

  // Runs one job with core_done in the first BUSY cycle (core returns key^text)
  task automatic run_job(output int g, output logic [127:0] ck, output int rc,
                         output logic [127:0] rd);
    int ones;
    #1;
    g = -1; ones = 0;
    for (int c = 0; c < NCH; c++) if (req_ready[c]) begin g = c; ones++; end
    if (ones != 1) g = -1;
    tick(); #1; ck = core_key;
    tick();
    core_done = 1'b1;
    core_text_out = (g >= 0) ? (key_tab[g] ^ text_tab[g]) : 128'h0;
    tick();
    core_done = 1'b0; #1;
    rc = res_valid ? int'(res_ch) : -1;
    rd = res_data;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    total++; if (core_ld !== 1'b0) begin bad++; $display("FAIL reset_core_ld: got %b want 0", core_ld); end
    total++; if (core_key !== 128'h0 || core_text_in !== 128'h0) begin bad++; $display("FAIL reset_core_job: got %h/%h want 0/0", core_key, core_text_in); end
    total++; if (res_valid !== 1'b0 || res_err !== 1'b0 || res_ch !== 3'd0 || res_data !== 128'h0) begin bad++;
      $display("FAIL reset_res: got v=%b e=%b ch=%0d d=%h want all 0", res_valid, res_err, res_ch, res_data); end
    $display("test_reset done");
  endtask

  task automatic test_single_job();
    logic [127:0] k, p, c;
    int ld_count;
    k = 128'h000102030405060708090a0b0c0d0e0f;
    p = 128'h00112233445566778899aabbccddeeff;
    c = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    do_reset();
    req_key[256 +: 128] = k; req_text[256 +: 128] = p;
    req_valid = 4'b0100; #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    tick(); req_valid = '0; #1;
    total++; if (core_ld !== 1'b1) begin bad++; $display("FAIL single_ld: got %b want 1", core_ld); end
    total++; if (core_key !== k || core_text_in !== p) begin bad++; $display("FAIL single_core_job: got %h/%h want %h/%h", core_key, core_text_in, k, p); end
    ld_count = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (core_ld) ld_count++;
      if (i == 10) begin core_done = 1'b1; core_text_out = c; end
    end
    tick(); core_done = 1'b0; #1;
    total++; if (ld_count != 0) begin bad++; $display("FAIL single_extra_ld: got %0d want 0", ld_count); end
    total++; if (res_valid !== 1'b1 || res_ch !== 3'd2 || res_data !== c || res_err !== 1'b0) begin bad++;
      $display("FAIL single_result: got v=%b ch=%0d d=%h e=%b want v=1 ch=2 d=%h e=0", res_valid, res_ch, res_data, res_err, c); end
    res_ready = 1'b1; tick(); res_ready = 1'b0; #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_release: got %b want 0", res_valid); end
    $display("test_single_job done");
  endtask

  task automatic test_fairness();
    int g, rc; logic [127:0] ck, rd;
    do_reset(); load_tables();
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      run_job(g, ck, rc, rd);
      total++; if (g != i % 4) begin bad++; $display("FAIL fair_grant%0d: got %0d want %0d", i, g, i % 4); end
      total++; if (ck !== key_tab[i % 4]) begin bad++; $display("FAIL fair_key%0d: got %h want %h", i, ck, key_tab[i % 4]); end
      total++; if (rc != i % 4 || rd !== (key_tab[i % 4] ^ text_tab[i % 4])) begin bad++;
        $display("FAIL fair_result%0d: got ch=%0d d=%h want ch=%0d d=%h", i, rc, rd, i % 4, key_tab[i % 4] ^ text_tab[i % 4]); end
      $display("fair job %0d grant=%0d res_ch=%0d", i, g, rc);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [127:0] d;
    do_reset(); load_tables();
    d = key_tab[1] ^ text_tab[1];
    req_valid = 4'b0010; #1;
    tick(); req_valid = 4'hF;
    tick(); core_done = 1'b1; core_text_out = d;
    tick(); core_done = 1'b0; #1;
    total++; if (res_valid !== 1'b1 || res_ch !== 3'd1 || res_data !== d) begin bad++;
      $display("FAIL bp_enter: got v=%b ch=%0d d=%h want v=1 ch=1 d=%h", res_valid, res_ch, res_data, d); end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (res_valid !== 1'b1 || res_ch !== 3'd1 || res_data !== d || req_ready !== 4'b0 || core_ld !== 1'b0) begin bad++;
        $display("FAIL bp_hold%0d: got v=%b ch=%0d d=%h rdy=%b ld=%b want v=1 ch=1 d=%h rdy=0000 ld=0",
                 i, res_valid, res_ch, res_data, req_ready, core_ld, d); end
    end
    res_ready = 1'b1; tick(); res_ready = 1'b0; #1;
    total++; if (req_ready !== 4'b0100 || res_valid !== 1'b0) begin bad++; $display("FAIL bp_next: got rdy=%b v=%b want rdy=0100 v=0", req_ready, res_valid); end
    req_valid = '0;
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid_busy();
    int g, rc; logic [127:0] ck, rd; int seen;
    do_reset(); load_tables();
    req_valid = 4'b1000;
    run_job(g, ck, rc, rd);
    tick(); req_valid = '0;
    tick(); tick();
    rst = 1'b0; #1;
    total++; if (core_ld !== 1'b0 || core_key !== 128'h0 || core_text_in !== 128'h0 || req_ready !== 4'b0) begin bad++;
      $display("FAIL midrst_core: got ld=%b k=%h t=%h rdy=%b want all 0", core_ld, core_key, core_text_in, req_ready); end
    total++; if (res_valid !== 1'b0 || res_ch !== 3'd0 || res_data !== 128'h0 || res_err !== 1'b0) begin bad++;
      $display("FAIL midrst_res: got v=%b ch=%0d d=%h e=%b want all 0", res_valid, res_ch, res_data, res_err); end
    tick(); tick(); rst = 1'b1;
    core_done = 1'b1; core_text_out = 128'hDEAD;
    tick(); core_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (res_valid) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen); end
    req_valid = 4'b1001; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL midrst_first_grant: got %b want 0001", req_ready); end
    req_valid = '0;
    $display("test_reset_mid_busy done");
  endtask

  task automatic test_spurious_done();
    int g, rc; logic [127:0] ck, rd, e2;
    do_reset(); load_tables();
    req_valid = 4'b0010;
    run_job(g, ck, rc, rd);
    req_valid = '0;
    core_done = 1'b1; core_text_out = 128'h1234;
    tick(); core_done = 1'b0; #1;
    total++; if (res_valid !== 1'b0 || res_data !== rd || core_ld !== 1'b0) begin bad++;
      $display("FAIL spur_idle: got v=%b d=%h ld=%b want v=0 d=%h ld=0", res_valid, res_data, core_ld, rd); end
    e2 = key_tab[2] ^ text_tab[2];
    req_valid = 4'b0100;
    tick(); req_valid = '0;
    tick(); core_done = 1'b1; core_text_out = e2;
    tick(); core_text_out = 128'h5555;
    tick(); core_done = 1'b0; #1;
    total++; if (res_valid !== 1'b1 || res_data !== e2 || res_ch !== 3'd2 || core_ld !== 1'b0) begin bad++;
      $display("FAIL spur_resp: got v=%b d=%h ch=%0d ld=%b want v=1 d=%h ch=2 ld=0", res_valid, res_data, res_ch, core_ld, e2); end
    res_ready = 1'b1; tick(); res_ready = 1'b0; #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL spur_release: got %b want 0", res_valid); end
    $display("test_spurious_done done");
  endtask

`ifdef AES_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int g, rc; logic [127:0] ck, rd;
    do_reset(); load_tables();
    req_valid = 4'b0010;
    run_job(g, ck, rc, rd);
    req_valid = 4'b0001;
    tick(); req_valid = '0;
    tick();
    repeat (15) tick();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL tmo_early: got %b want 0", res_valid); end
    tick();
    total++; if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 128'h0 || res_ch !== 3'd0) begin bad++;
      $display("FAIL tmo_fire: got v=%b e=%b d=%h ch=%0d want v=1 e=1 d=0 ch=0", res_valid, res_err, res_data, res_ch); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    req_valid = 4'b0001;
    tick(); req_valid = '0;
    tick();
    repeat (15) tick();
    core_done = 1'b1; core_text_out = 128'hF00D;
    tick(); core_done = 1'b0; #1;
    total++; if (res_valid !== 1'b1 || res_err !== 1'b0 || res_data !== 128'hF00D) begin bad++;
      $display("FAIL tmo_done_wins: got v=%b e=%b d=%h want v=1 e=0 d=f00d", res_valid, res_err, res_data); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    $display("test_timeout done");
  endtask
`else
  task automatic test_no_timeout();
    int seen;
    do_reset(); load_tables();
    req_valid = 4'b0001;
    tick(); req_valid = '0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin tick(); if (res_valid) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL notmo_wait: got %0d valid cycles want 0", seen); end
    core_done = 1'b1; core_text_out = 128'hBEEF;
    tick(); core_done = 1'b0; #1;
    total++; if (res_valid !== 1'b1 || res_err !== 1'b0 || res_data !== 128'hBEEF) begin bad++;
      $display("FAIL notmo_result: got v=%b e=%b d=%h want v=1 e=0 d=beef", res_valid, res_err, res_data); end
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    $display("test_no_timeout done");
  endtask
`endif

  initial begin
    test_reset();
    test_single_job();
    test_fairness();
    test_backpressure();
    test_reset_mid_busy();
    test_spurious_done();
`ifdef AES_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
